// File: rtl/fpmul_pkg.sv
// Shared types and constants for the FP multiplier driver and its FP helpers.
package fpmul_pkg;

  localparam int unsigned SIGN_W       = 1;
  localparam int unsigned EXP_W        = 8;
  localparam int unsigned MAN_W        = 23;
  localparam int unsigned WORD_W       = SIGN_W + EXP_W + MAN_W;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned DRAIN_CYCLES = 16;

  localparam logic [WORD_W-1:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  FP_EXP_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
  } fp32_t;

endpackage

// File: rtl/fpmul_driver_if.sv
// Operand/result handshakes plus the multiplier control bus of fpmul_driver.
interface fpmul_driver_if;
  import fpmul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_p;
  logic              out_uf;
  logic              out_of;
  logic              out_nan;
  logic              out_inf;
  logic              out_zero;
  logic              out_timeout;

  logic              fpm_start;
  logic [WORD_W-1:0] fpm_a;
  logic [WORD_W-1:0] fpm_b;
  logic              fpm_done;
  logic              fpm_uf;
  logic              fpm_of;
  logic [WORD_W-1:0] fpm_p;

  logic              busy;

  // Driver side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    input  fpm_done, fpm_uf, fpm_of, fpm_p,
    output in_ready, out_valid, out_p, out_uf, out_of,
    output out_nan, out_inf, out_zero, out_timeout,
    output fpm_start, fpm_a, fpm_b, busy
  );

  // Environment side: operand source, result sink and the multiplier.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    output fpm_done, fpm_uf, fpm_of, fpm_p,
    input  in_ready, out_valid, out_p, out_uf, out_of,
    input  out_nan, out_inf, out_zero, out_timeout,
    input  fpm_start, fpm_a, fpm_b, busy
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier: NaN / infinity / zero (sign ignored).
module fp_classify
  import fpmul_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic              nan_c_o,
  output logic              inf_c_o,
  output logic              zero_c_o
);

  fp32_t f;
  logic  exp_ones;
  logic  man_zero;
  logic  unused_sign;

  assign f           = word_i;
  assign unused_sign = f.sign;
  assign exp_ones    = (f.exp == FP_EXP_ONES);
  assign man_zero    = (f.man == '0);

  assign nan_c_o  = exp_ones & ~man_zero;
  assign inf_c_o  = exp_ones &  man_zero;
  assign zero_c_o = (f.exp == '0) & man_zero;

endmodule

// File: rtl/fpmul_driver.sv
// Sequences one operand pair at a time through an external FP multiplier.
// Optional Done watchdog enabled by defining FPMUL_DRIVER_TIMEOUT_EN.
module fpmul_driver
  import fpmul_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  fpmul_driver_if.slave   bus
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              fpm_start_q, fpm_start_d;
  logic [WORD_W-1:0] fpm_a_q, fpm_a_d;
  logic [WORD_W-1:0] fpm_b_q, fpm_b_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_p_q, out_p_d;
  logic              out_uf_q, out_uf_d;
  logic              out_of_q, out_of_d;
  logic              out_nan_q, out_nan_d;
  logic              out_inf_q, out_inf_d;
  logic              out_zero_q, out_zero_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] cap_word_c;
  logic              cls_nan_c, cls_inf_c, cls_zero_c;

`ifdef FPMUL_DRIVER_TIMEOUT_EN
  logic              out_timeout_q, out_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
  logic              unused_tmo;
  assign unused_tmo = ^CNT_W'(TIMEOUT_CYCLES);
`endif

  // Classification runs on whatever word is about to be captured into out_p.
  fp_classify u_classify (
    .word_i   (cap_word_c),
    .nan_c_o  (cls_nan_c),
    .inf_c_o  (cls_inf_c),
    .zero_c_o (cls_zero_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    fpm_a_d    = fpm_a_q;
    fpm_b_d    = fpm_b_q;
    out_p_d    = out_p_q;
    out_uf_d   = out_uf_q;
    out_of_d   = out_of_q;
    out_nan_d  = out_nan_q;
    out_inf_d  = out_inf_q;
    out_zero_d = out_zero_q;
    cap_word_c = bus.fpm_p;
`ifdef FPMUL_DRIVER_TIMEOUT_EN
    out_timeout_d = out_timeout_q;
    cnt_d         = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = ISSUE;
          fpm_a_d = bus.in_a;
          fpm_b_d = bus.in_b;
`ifdef FPMUL_DRIVER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ISSUE: begin
        if (bus.fpm_done) begin
          state_d    = HOLD;
          out_p_d    = bus.fpm_p;
          out_uf_d   = bus.fpm_uf;
          out_of_d   = bus.fpm_of;
          out_nan_d  = cls_nan_c;
          out_inf_d  = cls_inf_c;
          out_zero_d = cls_zero_c;
`ifdef FPMUL_DRIVER_TIMEOUT_EN
          out_timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end

`ifdef FPMUL_DRIVER_TIMEOUT_EN
      // Give a late Done a bounded window to land, then report a quiet NaN.
      DRAIN: begin
        cap_word_c = FP_QNAN;
        if (bus.fpm_done || (cnt_q == CNT_W'(DRAIN_CYCLES - 1))) begin
          state_d       = HOLD;
          out_p_d       = FP_QNAN;
          out_uf_d      = 1'b0;
          out_of_d      = 1'b0;
          out_nan_d     = cls_nan_c;
          out_inf_d     = cls_inf_c;
          out_zero_d    = cls_zero_c;
          out_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    fpm_start_d = (state_d == ISSUE);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      fpm_start_q <= 1'b0;
      fpm_a_q     <= '0;
      fpm_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_uf_q    <= 1'b0;
      out_of_q    <= 1'b0;
      out_nan_q   <= 1'b0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FPMUL_DRIVER_TIMEOUT_EN
      out_timeout_q <= 1'b0;
      cnt_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      fpm_start_q <= fpm_start_d;
      fpm_a_q     <= fpm_a_d;
      fpm_b_q     <= fpm_b_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_uf_q    <= out_uf_d;
      out_of_q    <= out_of_d;
      out_nan_q   <= out_nan_d;
      out_inf_q   <= out_inf_d;
      out_zero_q  <= out_zero_d;
      busy_q      <= busy_d;
`ifdef FPMUL_DRIVER_TIMEOUT_EN
      out_timeout_q <= out_timeout_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.fpm_start = fpm_start_q;
  assign bus.fpm_a     = fpm_a_q;
  assign bus.fpm_b     = fpm_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_uf    = out_uf_q;
  assign bus.out_of    = out_of_q;
  assign bus.out_nan   = out_nan_q;
  assign bus.out_inf   = out_inf_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.busy      = busy_q;
`ifdef FPMUL_DRIVER_TIMEOUT_EN
  assign bus.out_timeout = out_timeout_q;
`else
  assign bus.out_timeout = 1'b0;
`endif

endmodule

// File: doc/fpmul_driver.md
FPMUL_DRIVER -- requirements
Module: fpmul_driver

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 32, max cycles waiting for fpm_done before abort (range 8..255).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid/in_ready  in/out  1/1  operand-pair handshake.
REQ-005 in_a, in_b  in  32/32  IEEE-754 single operands.
REQ-006 out_valid/out_ready  out/in  1/1  result handshake.
REQ-007 out_p  out  32  captured product word.
REQ-008 out_uf, out_of, out_nan, out_inf, out_zero, out_timeout  out  1 each  result status.
REQ-009 fpm_start  out  1  Start level to the multiplier.
REQ-010 fpm_a, fpm_b  out  32/32  operands to the multiplier, registered.
REQ-011 fpm_done, fpm_uf, fpm_of  in  1 each  multiplier Done and flags.
REQ-012 fpm_p  in  32  multiplier product word.
REQ-013 busy  out  1  high in any state except IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, DRAIN, HOLD; all outputs registered.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, latch in_a/in_b into fpm_a/fpm_b, set fpm_start=1, clear timeout counter, go to ISSUE next cycle.
REQ-016 in_ready SHALL be 0 in ISSUE, DRAIN and HOLD; no operand queueing.
REQ-017 ISSUE: fpm_start and fpm_a/fpm_b held stable every cycle until fpm_done sampled high.
REQ-018 On fpm_done=1 in ISSUE: capture fpm_p, fpm_uf, fpm_of in the same edge; drive fpm_start=0 from the next cycle; go to HOLD with out_valid=1, out_timeout=0.
REQ-019 fpm_start SHALL be 0 in the cycle after fpm_done, guaranteeing the multiplier does not re-trigger on its return to its wait-for-Start state.
REQ-020 HOLD: out_valid=1 and all out_* stable until out_valid&out_ready; then IDLE, out_valid=0 next cycle.
REQ-021 fpm_done while in IDLE, DRAIN or HOLD SHALL be ignored for capture.
REQ-022 Classification from captured out_p: nan = exp==8'hFF & man!=0; inf = exp==8'hFF & man==0; zero = exp==0 & man==0; mutually exclusive.
REQ-023 Minimum throughput: one result per (multiplier latency + 3) cycles; back-to-back input accepted the cycle after out handshake.

Reset
REQ-024 On rst: state IDLE, fpm_start=0, fpm_a=fpm_b=0, out_valid=0, out_p=0, all status outputs 0, counter 0, in_ready=0 during reset cycle, 1 the following cycle.
REQ-025 rst mid-ISSUE SHALL drop fpm_start the next cycle; the multiplier is assumed reset by the same rst.

Configuration
REQ-026 Macro FPMUL_DRIVER_TIMEOUT_EN defined: 8-bit counter increments each ISSUE cycle; on reaching TIMEOUT_CYCLES without fpm_done, fpm_start=0, go to DRAIN.
REQ-027 DRAIN: wait for fpm_done (late Done swallowed) or at most 16 cycles, then HOLD with out_p=32'h7FC00000, out_timeout=1, out_uf=out_of=0, out_nan=1.
REQ-028 Macro undefined: no counter, no DRAIN state, out_timeout tied 0; ISSUE waits indefinitely.

Structure
REQ-029 Package fpmul_pkg: FSM state enum, FP_QNAN=32'h7FC00000, FP_EXP_ONES=8'hFF, field width constants (1/8/23).
REQ-030 Sub-module fp_classify (combinational, 32-bit in, nan/inf/zero out) shared with other FP blocks; only one instance.

Verification
REQ-031 in_a=0x3FC00000, in_b=0x40000000, model Done after 9 cycles with fpm_p=0x40400000 -> out_p=0x40400000, all flags 0, fpm_start low cycle after Done.
REQ-032 out_ready held 0 for 10 cycles in HOLD -> out_* stable, in_ready=0, fpm_start=0 throughout.
REQ-033 in_a=0x7F800000, in_b=0x00000000, model returns 0x7FFFFFFF -> out_nan=1, out_inf=0, out_zero=0.
REQ-034 TIMEOUT_EN, fpm_done never asserted -> fpm_start drops after 32 ISSUE cycles, result 0x7FC00000 with out_timeout=1 after DRAIN; Done arriving in DRAIN swallowed.
REQ-035 rst asserted 3 cycles into ISSUE -> next cycle fpm_start=0, busy=0, out_valid=0; new transaction then completes normally.
REQ-036 Two transactions with out_ready=1 and in_valid continuously high -> second accepted exactly one cycle after first out handshake; fpm_done outside ISSUE never produces out_valid.
